spi_seq_ctrl: RTL
=================

# spi_seq_ctrl

Multi-byte transfer sequencer that drives `spi_master` through its SFR bus, so the host never touches SPCR/SPSR/SPDR directly. The host loads up to DEPTH bytes into a TX buffer, supplies a config and length, and pulses `start`. The block then programs SPCR and, for each byte, writes SPDR, polls SPSR.SPIF, reads the received byte into an RX buffer and clears SPIF. It sits between the host register/pipe logic and `spi_master`; its bus ports connect one-to-one to `spi_master`.

## Interface
Parameters:
- DEPTH, 16: TX/RX buffer depth in bytes.
- AW, 4: buffer address width, log2(DEPTH).
- TIMEOUT, 16'hFFFF: maximum cycles spent polling per byte.
- SPCR_ADDR / SPSR_ADDR / SPDR_ADDR, 8'h02 / 8'h03 / 8'h04: SFR addresses.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock
- RESETn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a sequence; ignored while `busy`
- abort  in  1  one-cycle pulse; terminates an active sequence
- cfg  in  6  SPCR[5:0] (dord, mstr, cpol, cpha, spr); sampled on `start`
- len  in  AW+1  byte count, 0..DEPTH; sampled on `start`
- tx_we  in  1  TX buffer write enable
- tx_waddr  in  AW  TX buffer write address
- tx_wdata  in  8  TX buffer write data
- rx_raddr  in  AW  RX buffer read address
- rx_rdata  out  8  RX buffer read data, registered
- busy  out  1  high from the cycle after `start` until `done`
- done  out  1  one-cycle pulse at sequence end
- err  out  3  [0] poll timeout, [1] WCOL seen, [2] aborted; sticky until next `start`
- psel, penable, WE, RE  out  1  SFR bus strobes
- ADDRD  out  8  SFR address
- DATABI  out  8  write data to `spi_master`
- DATAB  in  8  read data from `spi_master` (combinational on ADDRD)

## Operation
- Bus access is two cycles. SETUP: psel=1, penable=0, WE or RE=1, ADDRD/DATABI valid. ACCESS: psel=1, penable=0→1, same ADDRD/DATABI. `spi_master` acts in SETUP.
- Read data is sampled from DATAB at the end of ACCESS. Between accesses all strobes are 0 and ADDRD=0.
- SPCR write value: {1'b0 (spie), 1'b1 (spe), cfg[5:0]}. The block polls, so interrupts are never enabled.
- FSM states:
  - IDLE: on `start`, if len=0 → DONE; else → CFG. Clear `err` and set idx=0.
  - CFG: write SPCR → LOAD.
  - LOAD: write SPDR = tx_buf[idx] → POLL. Load the timeout counter with TIMEOUT.
  - POLL: read SPSR.
    - If bit1=1, set err[1]; the byte still completes.
    - If bit0=1 → RDDAT; else repeat POLL.
    - The counter decrements every POLL cycle; at 0, set err[0] → ABORT.
  - RDDAT: read SPDR, rx_buf[idx] = DATAB → CLR.
  - CLR: write SPSR = 8'h03 (clears SPIF and WCOL) → NEXT.
  - NEXT: idx+1. If idx+1 == len → DONE, else → LOAD.
  - ABORT: write SPCR = 8'h00, which disables `spi_master` and resets its shifter → DONE.
  - DONE: pulse `done` → IDLE.
- `abort` in any non-IDLE state sets err[2]. The bus access in flight finishes its ACCESS cycle first, then the FSM goes to ABORT. `abort` in IDLE, DONE or ABORT is ignored.
- Buffers:
  - Host writes to the TX buffer are always accepted, including while `busy`. A write to tx_buf[idx] during LOAD SETUP: the old data is sent.
  - The RX buffer read port is always live; rx_rdata = rx_buf[rx_raddr] one cycle after the address.
- idx is AW+1 bits wide; len>DEPTH is clamped to DEPTH on capture.

## Timing
- Reset values: all bus outputs 0, rx_rdata=0, busy=0, done=0, err=0, FSM=IDLE. Buffer contents are not reset.
- Reset asserted mid-sequence returns to IDLE immediately, with bus strobes low within the reset cycle.
- `start` at cycle t: busy=1 at t+1, CFG SETUP at t+1.
- Per byte: LOAD 2 cycles + 2·k POLL cycles + RDDAT 2 + CLR 2 + NEXT 1.
- `done` asserts one cycle after the last NEXT, and busy=0 in that same cycle. A new `start` is accepted in the cycle `done` is high.
- len=0: done at t+1 with no bus activity and busy low throughout.
- `start` coinciding with `abort` in IDLE: the sequence starts.

## Test plan
- Reset: RESETn=0 mid-POLL → all outputs 0 in the same cycle; FSM returns to IDLE after release.
- Single byte, MISO loopback: tx_buf[0]=8'hA5, cfg=6'b010000 (MSB first, fosc/4), len=1 → SPCR write 8'h50; SPDR write A5; MOSI shows 1010_0101; rx_buf[0]=A5; one `done`; err=0.
- Burst: len=16, tx_buf[i]=i, loopback → rx_buf[i]=i for all i. Exactly 16 SPDR writes and 16 SPSR clears; `done` once; idx wraps cleanly at DEPTH.
- Timeout: SPIF forced low by a bus-model override, TIMEOUT=16'h0010 → err=3'b001 after 16 POLL cycles, then SPCR write 8'h00, then `done`.
- Abort: `abort` during byte 3 of 8 → current access completes, SPCR=8'h00 written, err[2]=1, `done`; rx_buf[0..1] valid.
- Edge cases:
  - len=0 → done at t+1, no psel.
  - `start` while busy → ignored, no restart.
  - Next `start` clears err.

Source files
------------

// File: rtl/spi_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_seq_ctrl
// Brief    : Multi-byte SPI transfer sequencer that drives spi_master through
//            its SFR bus (SPCR setup, per-byte SPDR write / SPIF poll / read).
// Revision : 1.0 - initial release
// ============================================================================
module spi_seq_ctrl #(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF,
    parameter logic [7:0]  SPCR_ADDR = 8'h02,
    parameter logic [7:0]  SPSR_ADDR = 8'h03,
    parameter logic [7:0]  SPDR_ADDR = 8'h04
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          start,
    input  logic          abort,
    input  logic [5:0]    cfg,
    input  logic [AW:0]   len,
    input  logic          tx_we,
    input  logic [AW-1:0] tx_waddr,
    input  logic [7:0]    tx_wdata,
    input  logic [AW-1:0] rx_raddr,
    output logic [7:0]    rx_rdata,
    output logic          busy,
    output logic          done,
    output logic [2:0]    err,
    output logic          psel,
    output logic          penable,
    output logic          WE,
    output logic          RE,
    output logic [7:0]    ADDRD,
    output logic [7:0]    DATABI,
    input  logic [7:0]    DATAB
);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_LOAD, S_POLL, S_RDDAT, S_CLR, S_NEXT, S_ABORT, S_DONE
    } state_t;

    localparam logic [AW:0] c_max_len  = (AW+1)'(DEPTH);
    localparam logic [7:0]  c_spsr_clr = 8'h03;

    state_t        r_state, w_nx;
    logic          r_ph, r_abort_pend, w_adv, w_abort, w_abortable, w_tmo_exp, w_rx_we;
    logic [AW:0]   r_idx, r_len, w_idx_inc;
    logic [AW-1:0] w_ld_idx;
    logic [15:0]   r_tmo;
    logic [2:0]    r_err;
    logic          r_busy, r_done, r_psel, r_penable, r_we, r_re;
    logic [7:0]    r_addr, r_wdata, r_rx_rdata;
    logic          w_psel, w_we, w_re;
    logic [7:0]    w_addr, w_wdata;
    logic [7:0]    r_tx_buf [DEPTH];
    logic [7:0]    r_rx_buf [DEPTH];

    assign w_abort     = abort | r_abort_pend;
    assign w_abortable = !(r_state inside {S_IDLE, S_DONE, S_ABORT});
    assign w_idx_inc   = r_idx + (AW+1)'(1);
    assign w_ld_idx    = (r_state == S_NEXT) ? w_idx_inc[AW-1:0] : r_idx[AW-1:0];
    assign w_tmo_exp   = (r_tmo <= 16'd1);
    assign w_rx_we     = (r_state == S_RDDAT) && r_ph;

    // Bus states advance only at the end of ACCESS (r_ph=1); others every cycle.
    always_comb begin
        w_nx  = r_state;
        w_adv = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_adv = 1'b1;
                if (start) w_nx = (len == '0) ? S_DONE : S_CFG;
                else       w_nx = S_IDLE;
            end
            S_CFG:   begin w_adv = r_ph; w_nx = w_abort ? S_ABORT : S_LOAD; end
            S_LOAD:  begin w_adv = r_ph; w_nx = w_abort ? S_ABORT : S_POLL; end
            S_POLL: begin
                w_adv = r_ph;
                if (w_abort)       w_nx = S_ABORT;
                else if (DATAB[0]) w_nx = S_RDDAT;
                else if (w_tmo_exp) w_nx = S_ABORT;
                else               w_nx = S_POLL;
            end
            S_RDDAT: begin w_adv = r_ph; w_nx = w_abort ? S_ABORT : S_CLR; end
            S_CLR:   begin w_adv = r_ph; w_nx = w_abort ? S_ABORT : S_NEXT; end
            S_NEXT: begin
                w_adv = 1'b1;
                if (w_abort)                 w_nx = S_ABORT;
                else if (w_idx_inc == r_len) w_nx = S_DONE;
                else                         w_nx = S_LOAD;
            end
            S_ABORT: begin w_adv = r_ph; w_nx = S_DONE; end
            default: begin w_adv = 1'b1; w_nx = S_IDLE; end
        endcase
    end

    // SETUP-phase bus values for the state being entered.
    always_comb begin
        w_psel  = 1'b0;
        w_we    = 1'b0;
        w_re    = 1'b0;
        w_addr  = 8'h00;
        w_wdata = 8'h00;
        case (w_nx)
            S_CFG:   begin w_psel = 1'b1; w_we = 1'b1; w_addr = SPCR_ADDR; w_wdata = {2'b01, cfg}; end
            S_LOAD:  begin w_psel = 1'b1; w_we = 1'b1; w_addr = SPDR_ADDR; w_wdata = r_tx_buf[w_ld_idx]; end
            S_POLL:  begin w_psel = 1'b1; w_re = 1'b1; w_addr = SPSR_ADDR; end
            S_RDDAT: begin w_psel = 1'b1; w_re = 1'b1; w_addr = SPDR_ADDR; end
            S_CLR:   begin w_psel = 1'b1; w_we = 1'b1; w_addr = SPSR_ADDR; w_wdata = c_spsr_clr; end
            S_ABORT: begin w_psel = 1'b1; w_we = 1'b1; w_addr = SPCR_ADDR; end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state      <= S_IDLE;
            r_ph         <= 1'b0;
            r_abort_pend <= 1'b0;
            r_idx        <= '0;
            r_len        <= '0;
            r_tmo        <= '0;
            r_err        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rx_rdata   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_adv) begin
                r_state      <= w_nx;
                r_ph         <= 1'b0;
                r_abort_pend <= 1'b0;
                r_psel       <= w_psel;
                r_penable    <= 1'b0;
                r_we         <= w_we;
                r_re         <= w_re;
                r_addr       <= w_addr;
                r_wdata      <= w_wdata;
            end else begin
                r_ph      <= 1'b1;
                r_penable <= 1'b1;
                if (abort && w_abortable) r_abort_pend <= 1'b1;
            end
            if (abort && w_abortable) r_err[2] <= 1'b1;
            if ((r_state == S_IDLE || r_state == S_DONE) && start) begin
                r_err  <= '0;
                r_idx  <= '0;
                r_len  <= (len > c_max_len) ? c_max_len : len;
                r_busy <= (len != '0);
            end
            if (w_adv && w_nx == S_DONE) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
            if (r_state == S_LOAD)                      r_tmo <= TIMEOUT;
            else if (r_state == S_POLL && r_tmo != '0) r_tmo <= r_tmo - 16'd1;
            if (r_state == S_POLL && r_ph) begin
                if (DATAB[1]) r_err[1] <= 1'b1;
                if (!w_abort && !DATAB[0] && w_tmo_exp) r_err[0] <= 1'b1;
            end
            if (r_state == S_NEXT) r_idx <= w_idx_inc;
            r_rx_rdata <= r_rx_buf[rx_raddr];
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_we)   r_tx_buf[tx_waddr]       <= tx_wdata;
        if (w_rx_we) r_rx_buf[r_idx[AW-1:0]] <= DATAB;
    end

    assign rx_rdata = r_rx_rdata;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign psel     = r_psel;
    assign penable  = r_penable;
    assign WE       = r_we;
    assign RE       = r_re;
    assign ADDRD    = r_addr;
    assign DATABI   = r_wdata;

endmodule
`default_nettype wire
